// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, a registered carry and
// shift registers produce a WIDTH-bit sum/difference with carry, overflow and zero flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;

    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic             load;
    logic             step;
    logic             last;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_final;

    // The single adder cell shared by every bit position.
    full_adder u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Value the result shift register will hold after the final RUN edge.
    assign res_final = {fa_s, res_sh_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DONE always falls back to IDLE, so a held start is re-accepted one
    // cycle after the done pulse.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
        end else if (load) begin
            a_sh_reg  <= a;
            b_sh_reg  <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
        end else if (step) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_sh_reg <= res_final;
            carry_reg  <= fa_c;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    // On the MSB step carry_reg is the carry into the MSB, fa_c the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg   <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (last) begin
            result_reg   <= res_final;
            cout_reg     <= fa_c;
            overflow_reg <= carry_reg ^ fa_c;
            zero_reg     <= (res_final == '0);
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule
